// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg: mode encoding and pipeline latency shared by the Gray converter pipeline
package gray_conv_pkg;
    typedef enum logic {MODE_B2G = 1'b0, MODE_G2B = 1'b1} conv_mode_e;
    localparam int GC_LATENCY = 2;
endpackage

// File: rtl/gray_conv_core.sv
// gray_conv_core: combinational binary<->Gray conversion selected by mode
module gray_conv_core
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data,
    input  conv_mode_e       mode,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH-1:0] bin;
    // Gray->binary is a running XOR from the MSB down; binary->Gray is a shifted XOR
    always_comb begin
        bin = '0;
        bin[WIDTH-1] = data[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) bin[i] = bin[i+1] ^ data[i];
        result = (mode == MODE_G2B) ? bin : data ^ (data >> 1);
    end
endmodule

// File: rtl/gray_conv_pipe.sv
// gray_conv_pipe: two-stage valid/ready binary<->Gray converter with saturating transfer counter
module gray_conv_pipe
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_orig,
    output logic [CNT_W-1:0] conv_count
);
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d, s2_orig_q, s2_orig_d;
    logic [WIDTH-1:0] conv_data;
    conv_mode_e       s1_mode_q, s1_mode_d, s2_mode_q, s2_mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_adv, s2_adv, s1_load, s2_load;

    gray_conv_core #(.WIDTH(WIDTH)) u_core (
        .data  (s1_data_q),
        .mode  (s1_mode_q),
        .result(conv_data)
    );

    // Stage advance and next state; data registers only reload when a valid word moves in
    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        s1_load    = s1_adv && in_valid;
        s2_load    = s2_adv && s1_valid_q;
        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        s1_data_d  = s1_load ? in_data : s1_data_q;
        s1_mode_d  = s1_load ? conv_mode_e'(in_mode) : s1_mode_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s2_data_d  = s2_load ? conv_data : s2_data_q;
        s2_orig_d  = s2_load ? s1_data_q : s2_orig_q;
        s2_mode_d  = s2_load ? s1_mode_q : s2_mode_q;
        cnt_d      = (s2_valid_q && out_ready && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Pipeline and counter registers; reset discards any in-flight words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= MODE_B2G;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_orig_q  <= '0;
            s2_mode_q  <= MODE_B2G;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_orig_q  <= s2_orig_d;
            s2_mode_q  <= s2_mode_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready   = s1_adv;
    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign out_orig   = s2_orig_q;
    assign out_mode   = s2_mode_q;
    assign conv_count = cnt_q;
endmodule

// File: tb/tb_gray_conv_pipe.sv
// tb_gray_conv_pipe: randomized and directed checks of gray_conv_pipe against a queue-based model
module tb_gray_conv_pipe;
    import gray_conv_pkg::*;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] data;
        logic         mode;
        logic [W-1:0] orig;
    } word_t;

    logic         clk = 0, rst_n = 0, in_valid = 0, in_mode = 0, out_ready = 0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid, out_mode, in_ready3, out_valid3, out_mode3;
    logic [W-1:0] out_data, out_orig, out_data3, out_orig3;
    logic [15:0]  conv_count;
    logic [2:0]   conv_count3;

    int           checks = 0, errors = 0, xfers = 0;
    word_t        q[$];
    logic [W-1:0] out_log[$];
    logic         hold = 0, hold_mode = 0;
    logic [W-1:0] hold_data = '0, hold_orig = '0;
    logic         s_acc, s_ov, s_ir, s_om;
    logic [W-1:0] s_od, s_oo;

    always #5 clk = ~clk;

    gray_conv_pipe #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_mode(out_mode), .out_orig(out_orig), .conv_count(conv_count)
    );

    gray_conv_pipe #(.WIDTH(W), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid3), .out_ready(out_ready),
        .out_data(out_data3), .out_mode(out_mode3), .out_orig(out_orig3), .conv_count(conv_count3)
    );

    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic m);
        logic [W-1:0] r;
        if (!m) return x ^ (x >> 1);
        for (int i = 0; i < W; i++) r[i] = ^(x >> i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon();
        word_t w;
        int    lim3;
        if (!rst_n) begin
            q.delete();
            xfers = 0;
            hold  = 0;
            chk("rst_out_valid", 32'(out_valid), 0);
            return;
        end
        lim3 = xfers > 7 ? 7 : xfers;
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2 || out_ready));
        chk("conv_count", 32'(conv_count), 32'(xfers));
        chk("conv_count3", 32'(conv_count3), 32'(lim3));
        if (q.size() == 2) chk("full_out_valid", 32'(out_valid), 1);
        if (hold) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", 32'(out_data), 32'(hold_data));
            chk("hold_orig", 32'(out_orig), 32'(hold_orig));
            chk("hold_mode", 32'(out_mode), 32'(hold_mode));
        end
        if (out_valid) begin
            if (q.size() == 0) chk("spurious_out", 32'(out_data), 32'hdead);
            else begin
                w = q[0];
                chk("out_data", 32'(out_data), 32'(w.data));
                chk("out_mode", 32'(out_mode), 32'(w.mode));
                chk("out_orig", 32'(out_orig), 32'(w.orig));
                if (out_ready) begin
                    void'(q.pop_front());
                    xfers++;
                    out_log.push_back(out_data);
                end
            end
        end
        hold      = out_valid && !out_ready;
        hold_data = out_data;
        hold_orig = out_orig;
        hold_mode = out_mode;
        if (in_valid && in_ready) q.push_back('{data: model(in_data, in_mode), mode: in_mode, orig: in_data});
    endtask

    task automatic cyc();
        @(negedge clk);
        s_acc = in_valid && in_ready;
        s_ov  = out_valid;
        s_ir  = in_ready;
        s_od  = out_data;
        s_oo  = out_orig;
        s_om  = out_mode;
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [W-1:0] d, input logic m, output logic [W-1:0] r,
                           output logic mo, output logic [W-1:0] oo, output int lat);
        int n;
        in_valid = 1;
        in_data  = d;
        in_mode  = m;
        n = 0;
        do begin cyc(); n++; end while (!s_acc && n < 20);
        if (!s_acc) chk("accept_timeout", 0, 1);
        in_valid = 0;
        lat = 0;
        do begin cyc(); lat++; end while (!s_ov && lat < 20);
        if (!s_ov) chk("output_timeout", 0, 1);
        r  = s_od;
        mo = s_om;
        oo = s_oo;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] r, g, b, oo;
        logic         mo;
        int           lat, idx, base, x0, guard;
        logic [W-1:0] bp_exp[4];
        bp_exp = '{4'd0, 4'd1, 4'd3, 4'd2};

        chk("pin_b2g_1011", 32'(model(4'b1011, 1'b0)), 32'hE);
        chk("pin_g2b_1000", 32'(model(4'b1000, 1'b1)), 32'hF);
        chk("pin_g2b_1110", 32'(model(4'b1110, 1'b1)), 32'hB);

        #12;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_data", 32'(out_data), 0);
        chk("reset_out_orig", 32'(out_orig), 0);
        chk("reset_out_mode", 32'(out_mode), 0);
        chk("reset_count", 32'(conv_count), 0);
        @(posedge clk); #1;
        rst_n = 1;
        out_ready = 1;
        cyc();

        convert(4'b1011, 1'b0, r, mo, oo, lat);
        chk("t1_data", 32'(r), 32'hE);
        chk("t1_mode", 32'(mo), 0);
        chk("t1_orig", 32'(oo), 32'hB);
        chk("t1_latency", 32'(lat), 32'(GC_LATENCY));
        convert(4'b1110, 1'b1, r, mo, oo, lat);
        chk("t2_g2b_1110", 32'(r), 32'hB);
        chk("t2_mode", 32'(mo), 1);
        convert(4'b1000, 1'b1, r, mo, oo, lat);
        chk("t2_g2b_1000", 32'(r), 32'hF);
        convert(4'b1111, 1'b0, r, mo, oo, lat);
        chk("t2_b2g_1111", 32'(r), 32'h8);
        convert(4'b0000, 1'b0, r, mo, oo, lat);
        chk("t2_b2g_0", 32'(r), 0);

        for (int x = 0; x < 16; x++) begin
            convert(W'(x), 1'b0, g, mo, oo, lat);
            convert(g, 1'b1, b, mo, oo, lat);
            chk("roundtrip", 32'(b), 32'(x));
            convert(W'(x), 1'b1, g, mo, oo, lat);
            convert(g, 1'b0, b, mo, oo, lat);
            chk("roundtrip_inv", 32'(b), 32'(x));
        end
        repeat (3) cyc();

        out_ready = 0;
        idx = 0;
        base = out_log.size();
        for (int c = 0; c < 6; c++) begin
            in_valid = idx < 4;
            in_data  = W'(idx);
            in_mode  = 0;
            cyc();
            if (s_acc) idx++;
        end
        chk("bp_accepts", 32'(idx), 2);
        chk("bp_in_ready", 32'(s_ir), 0);
        out_ready = 1;
        guard = 0;
        while (idx < 4 && guard < 20) begin
            in_valid = 1;
            in_data  = W'(idx);
            cyc();
            if (s_acc) idx++;
            guard++;
        end
        in_valid = 0;
        repeat (4) cyc();
        chk("bp_out_count", 32'(out_log.size() - base), 4);
        for (int k = 0; k < 4; k++)
            if (base + k < out_log.size()) chk("bp_order", 32'(out_log[base+k]), 32'(bp_exp[k]));

        x0 = xfers;
        for (int i = 0; i < 25; i++) begin
            in_valid = 1;
            in_data  = W'($urandom_range(0, 15));
            in_mode  = 1'($urandom_range(0, 1));
            cyc();
            chk("fr_accept", 32'(s_acc), 1);
        end
        in_valid = 0;
        cyc();
        cyc();
        chk("fr_outputs_26cyc", 32'(xfers - x0), 25);
        chk("fr_drained", 32'(q.size()), 0);

        out_ready = 0;
        in_valid  = 1;
        in_data   = 4'h5;
        in_mode   = 0;
        cyc();
        in_data = 4'h9;
        in_mode = 1;
        cyc();
        in_valid = 0;
        chk("rst_buffered", 32'(q.size()), 2);
        #2 rst_n = 0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 0);
        chk("rst_async_count", 32'(conv_count), 0);
        chk("rst_async_count3", 32'(conv_count3), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        cyc();
        rst_n = 1;
        out_ready = 1;
        convert(4'b0110, 1'b0, r, mo, oo, lat);
        chk("post_rst_data", 32'(r), 32'h5);
        chk("post_rst_latency", 32'(lat), 32'(GC_LATENCY));
        chk("post_rst_count", 32'(conv_count), 1);

        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            in_mode   = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        in_valid  = 0;
        out_ready = 1;
        repeat (4) cyc();
        chk("rand_drained", 32'(q.size()), 0);
        chk("cnt3_saturated", 32'(conv_count3), 7);
        chk("cnt16_total", 32'(conv_count), 32'(xfers));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
